// File: rtl/clock_pkg.sv
// Shared definitions for the operate interface between the button encoder and the time keeper.
// Holds the operation codes, FSM state encoding and the BCD mod-60 step helper.
package clock_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_SEC0 = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  typedef struct packed {
    logic       carry;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_step_t;

  // Adds 0, 1 or 2 to a two-digit BCD value modulo 60; carry flags the wrap past 59.
  function automatic bcd_step_t bcd_mod60_add(input logic [3:0] tens,
                                              input logic [3:0] ones,
                                              input logic [1:0] amt);
    bcd_step_t  r;
    logic [4:0] o_sum;
    o_sum   = {1'b0, ones} + {3'b000, amt};
    r.carry = 1'b0;
    r.tens  = tens;
    r.ones  = o_sum[3:0];
    if (o_sum >= 5'd10) begin
      r.ones = 4'(o_sum - 5'd10);
      if (tens >= 4'd5) begin
        r.tens  = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.tens = tens + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_op_decoder_bcd_mod60_counter.sv
// Two-digit BCD counter 00..59 with single/double increment and synchronous clear.
// carry is combinational and marks the step that wraps the count back through 00.
module bcd_mod60_counter
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       inc2,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry
);

  bcd_step_t  step;
  logic [1:0] amt;

  always_comb begin
    amt = 2'd0;
    if (inc2) begin
      amt = 2'd2;
    end else if (inc) begin
      amt = 2'd1;
    end
  end

  assign step  = bcd_mod60_add(tens, ones, amt);
  assign carry = step.carry & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clear) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc || inc2) begin
      ones <= step.ones;
      tens <= step.tens;
    end
  end

endmodule

// File: rtl/clock_op_decoder.sv
// Operate-interface consumer: decodes held op codes once per press, acknowledges via
// encoder_reset, and runs the prescaled BCD mm:ss counter with an hourly rollover pulse.
module clock_op_decoder
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] operate,
  output logic       encoder_reset,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       hour_pulse
);

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] prescaler;
  logic             tick;
  logic             op_accept;
  logic             do_madd;
  logic             do_sec0;
  logic             do_rst;
  logic             sec_inc;
  logic             sec_clr;
  logic             sec_carry;
  logic             sec_wrap;
  logic             min_inc;
  logic             min_inc2;
  logic             min_clr;
  logic             min_carry;
  logic             hour_pulse_d;

  assign tick = (prescaler == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    op_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (operate != OP_NONE) begin
          op_accept = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        if (operate == OP_NONE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign encoder_reset = (state_q == ST_ACK);

  assign do_madd = op_accept && (operate == OP_MADD);
  assign do_sec0 = op_accept && (operate == OP_SEC0);
  assign do_rst  = op_accept && (operate == OP_RST);

  // Zeroing ops swallow a coincident tick; a minute add lets it through and may stack a carry.
  assign sec_clr  = do_sec0 | do_rst;
  assign sec_inc  = tick & ~sec_clr;
  assign sec_wrap = sec_inc & sec_carry;
  assign min_clr  = do_rst;
  assign min_inc2 = do_madd & sec_wrap;
  assign min_inc  = (do_madd | sec_wrap) & ~min_inc2;

  assign hour_pulse_d = sec_wrap & min_carry & ~do_madd;

  bcd_mod60_counter u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .inc2  (1'b0),
    .clear (sec_clr),
    .ones  (sec_ones),
    .tens  (sec_tens),
    .carry (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .inc2  (min_inc2),
    .clear (min_clr),
    .ones  (min_ones),
    .tens  (min_tens),
    .carry (min_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prescaler  <= '0;
      hour_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      hour_pulse <= hour_pulse_d;
      if (sec_clr || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule
